// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic-array result drain.
package sa_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        DATA,
        CSUM
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         MAX_ACC_W     = 32;
    localparam int         RES_BUS_W     = 4 * MAX_ACC_W;
    localparam int         IDX_W         = 4;

    // SYNC byte + four results + checksum byte.
    function automatic int frame_len(input int acc_w);
        return 2 + 4 * acc_w / 8;
    endfunction

    // Results are packed {c11, c10, c01, c00} with each result LSB first.
    // With that packing, wire byte idx is simply byte idx of the packed vector.
    function automatic logic [7:0] sel_byte(input logic [RES_BUS_W-1:0] results,
                                            input logic [IDX_W-1:0]     idx);
        return results[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/sa_result_drain.sv
// Captures a 2x2 result set and streams it as SYNC, result bytes LSB first, XOR checksum.
// Latency: SYNC is presented on tx the cycle after the result set is captured.
// Backpressure: tx_data/state hold while tx_ready is low; res_ready stays low for the whole frame.
module sa_result_drain
    import sa_pkg::*;
#(
    parameter int         ACC_W     = 16,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic [ACC_W-1:0] res_c00,
    input  logic [ACC_W-1:0] res_c01,
    input  logic [ACC_W-1:0] res_c10,
    input  logic [ACC_W-1:0] res_c11,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             frame_done
);

    localparam int               DATA_BYTES = frame_len(ACC_W) - 2;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DATA_BYTES - 1);

    generate
        if ((ACC_W % 8) != 0 || ACC_W < 8 || ACC_W > MAX_ACC_W) begin : g_bad_acc_w
            $error("sa_result_drain: ACC_W must be 8, 16, 24 or 32");
        end
    endgenerate

    state_t               state;
    logic [4*ACC_W-1:0]   cap;
    logic [RES_BUS_W-1:0] cap_ext;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     idx_nxt;
    logic [7:0]           csum;
    logic                 tx_fire;

    assign cap_ext = RES_BUS_W'(cap);
    assign idx_nxt = idx + IDX_W'(1);
    assign tx_fire = tx_valid && tx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cap        <= '0;
            idx        <= '0;
            csum       <= 8'h00;
            res_ready  <= 1'b1;
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (res_valid) begin
                        cap       <= {res_c11, res_c10, res_c01, res_c00};
                        csum      <= 8'h00;
                        idx       <= '0;
                        res_ready <= 1'b0;
                        busy      <= 1'b1;
                        tx_valid  <= 1'b1;
                        tx_data   <= SYNC_BYTE;
                        state     <= SYNC;
                    end
                end
                SYNC: begin
                    if (tx_fire) begin
                        tx_data <= sel_byte(cap_ext, '0);
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (tx_fire) begin
                        csum <= csum ^ tx_data;
                        if (idx == LAST_IDX) begin
                            // Present the checksum including the byte just accepted.
                            tx_data <= csum ^ tx_data;
                            state   <= CSUM;
                        end else begin
                            idx     <= idx_nxt;
                            tx_data <= sel_byte(cap_ext, idx_nxt);
                        end
                    end
                end
                CSUM: begin
                    if (tx_fire) begin
                        tx_valid   <= 1'b0;
                        tx_data    <= 8'h00;
                        busy       <= 1'b0;
                        res_ready  <= 1'b1;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    tx_valid  <= 1'b0;
                    busy      <= 1'b0;
                    res_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sa_result_drain.sv
// Directed bench for sa_result_drain: byte scoreboard per instance (ACC_W=16 and ACC_W=8).
module tb_sa_result_drain;

    logic        clk = 1'b0;
    logic        rst;

    logic        rv16, rr16, txv16, txr16, busy16, fd16;
    logic [15:0] a00, a01, a10, a11;
    logic [7:0]  txd16;

    logic        rv8, rr8, txv8, txr8, busy8, fd8;
    logic [7:0]  b00, b01, b10, b11;
    logic [7:0]  txd8;

    logic [7:0]  q16[$];
    logic [7:0]  q8[$];
    int          tests = 0;
    int          fails = 0;
    int          fd16_cnt = 0;
    int          fd8_cnt = 0;

    always #5 clk = ~clk;

    sa_result_drain #(.ACC_W(16)) dut16 (
        .clk(clk), .rst(rst),
        .res_valid(rv16), .res_ready(rr16),
        .res_c00(a00), .res_c01(a01), .res_c10(a10), .res_c11(a11),
        .tx_data(txd16), .tx_valid(txv16), .tx_ready(txr16),
        .busy(busy16), .frame_done(fd16)
    );

    sa_result_drain #(.ACC_W(8)) dut8 (
        .clk(clk), .rst(rst),
        .res_valid(rv8), .res_ready(rr8),
        .res_c00(b00), .res_c01(b01), .res_c10(b10), .res_c11(b11),
        .tx_data(txd8), .tx_valid(txv8), .tx_ready(txr8),
        .busy(busy8), .frame_done(fd8)
    );

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: score any transfer happening at the coming edge, then step past it.
    task automatic tick();
        logic [7:0] e;
        @(negedge clk);
        if (txv16 === 1'b1 && txr16 === 1'b1) begin
            tests++;
            assert (q16.size() != 0) else begin
                fails++;
                $error("FAIL tx16_extra observed=%0h expected=none", txd16);
            end
            if (q16.size() != 0) begin
                e = q16.pop_front();
                chk("tx16_byte", {24'h0, txd16}, {24'h0, e});
            end
        end
        if (txv8 === 1'b1 && txr8 === 1'b1) begin
            tests++;
            assert (q8.size() != 0) else begin
                fails++;
                $error("FAIL tx8_extra observed=%0h expected=none", txd8);
            end
            if (q8.size() != 0) begin
                e = q8.pop_front();
                chk("tx8_byte", {24'h0, txd8}, {24'h0, e});
            end
        end
        if (fd16 === 1'b1) fd16_cnt++;
        if (fd8 === 1'b1) fd8_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic push16_model(input logic [15:0] c0, c1, c2, c3);
        logic [15:0] r[4];
        logic [7:0]  cs;
        logic [7:0]  by;
        r = '{c0, c1, c2, c3};
        cs = 8'h00;
        q16.push_back(8'hA5);
        for (int i = 0; i < 4; i++) begin
            for (int b = 0; b < 2; b++) begin
                by = r[i][8*b +: 8];
                cs ^= by;
                q16.push_back(by);
            end
        end
        q16.push_back(cs);
    endtask

    task automatic push16_ref();
        logic [7:0] t[10];
        t = '{8'hA5, 8'h34, 8'h12, 8'h01, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h80, 8'hA7};
        foreach (t[i]) q16.push_back(t[i]);
    endtask

    task automatic send16(input logic [15:0] c0, c1, c2, c3);
        int n = 0;
        while (rr16 !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("send16_ready", {31'h0, rr16}, 32'h1);
        a00 = c0; a01 = c1; a10 = c2; a11 = c3;
        rv16 = 1'b1;
        tick();
        rv16 = 1'b0;
    endtask

    task automatic drain16(input string tag);
        int n = 0;
        int start = fd16_cnt;
        while (fd16_cnt == start && n < 60) begin
            tick();
            n++;
        end
        chk({tag, "_frame_done"}, fd16_cnt - start, 1);
        chk({tag, "_queue_empty"}, q16.size(), 0);
    endtask

    initial begin
        logic [7:0] t8[6];
        int start;

        // Reset held two cycles with res_valid asserted
        rst = 1'b1;
        rv16 = 1'b1; a00 = 16'hDEAD; a01 = 16'hBEEF; a10 = 16'h5555; a11 = 16'hAAAA;
        txr16 = 1'b1;
        rv8 = 1'b0; b00 = 8'h00; b01 = 8'h00; b10 = 8'h00; b11 = 8'h00;
        txr8 = 1'b1;
        tick();
        tick();
        chk("rst_res_ready", {31'h0, rr16}, 32'h1);
        chk("rst_tx_valid", {31'h0, txv16}, 32'h0);
        chk("rst_tx_data", {24'h0, txd16}, 32'h0);
        chk("rst_busy", {31'h0, busy16}, 32'h0);
        chk("rst_frame_done", {31'h0, fd16}, 32'h0);
        rv16 = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        chk("post_rst_idle_valid", {31'h0, txv16}, 32'h0);
        chk("post_rst_idle_busy", {31'h0, busy16}, 32'h0);

        // Single frame at full rate
        push16_ref();
        send16(16'h1234, 16'h0001, 16'hFFFF, 16'h8000);
        chk("t2_sync_valid", {31'h0, txv16}, 32'h1);
        chk("t2_sync_data", {24'h0, txd16}, 32'hA5);
        chk("t2_busy", {31'h0, busy16}, 32'h1);
        chk("t2_res_ready_low", {31'h0, rr16}, 32'h0);
        start = fd16_cnt;
        repeat (10) tick();
        chk("t2_ten_cycles", q16.size(), 0);
        chk("t2_frame_done", {31'h0, fd16}, 32'h1);
        chk("t2_res_ready_back", {31'h0, rr16}, 32'h1);
        chk("t2_busy_clear", {31'h0, busy16}, 32'h0);
        chk("t2_tx_valid_clear", {31'h0, txv16}, 32'h0);
        tick();
        chk("t2_frame_done_pulse", {31'h0, fd16}, 32'h0);
        chk("t2_frame_done_count", fd16_cnt - start, 1);

        // Backpressure while 0x12 is presented
        push16_ref();
        send16(16'h1234, 16'h0001, 16'hFFFF, 16'h8000);
        tick();
        tick();
        txr16 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_hold_data", {24'h0, txd16}, 32'h12);
            chk("t3_hold_valid", {31'h0, txv16}, 32'h1);
        end
        txr16 = 1'b1;
        drain16("t3");

        // New result set offered mid-frame must be ignored
        push16_model(16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0789);
        send16(16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0789);
        repeat (3) tick();
        a00 = 16'h1111; a01 = 16'h2222; a10 = 16'h3333; a11 = 16'h4444;
        rv16 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t4_res_ready_low", {31'h0, rr16}, 32'h0);
        end
        rv16 = 1'b0;
        drain16("t4");
        tick();
        tick();
        chk("t4_no_recapture", {31'h0, busy16}, 32'h0);

        // Reset mid-frame, then a fresh frame
        push16_model(16'h0102, 16'h0304, 16'h0506, 16'h0708);
        send16(16'h0102, 16'h0304, 16'h0506, 16'h0708);
        repeat (5) tick();
        txr16 = 1'b0;
        rst = 1'b1;
        tick();
        chk("t5_rst_tx_valid", {31'h0, txv16}, 32'h0);
        chk("t5_rst_busy", {31'h0, busy16}, 32'h0);
        chk("t5_rst_res_ready", {31'h0, rr16}, 32'h1);
        rst = 1'b0;
        q16.delete();
        txr16 = 1'b1;
        push16_model(16'h9876, 16'h5432, 16'h10FE, 16'hDCBA);
        send16(16'h9876, 16'h5432, 16'h10FE, 16'hDCBA);
        chk("t5_fresh_sync", {24'h0, txd16}, 32'hA5);
        drain16("t5");

        // ACC_W=8 instance: 6-byte frame
        t8 = '{8'hA5, 8'h11, 8'h22, 8'h44, 8'h88, 8'hFF};
        foreach (t8[i]) q8.push_back(t8[i]);
        chk("t6_ready", {31'h0, rr8}, 32'h1);
        b00 = 8'h11; b01 = 8'h22; b10 = 8'h44; b11 = 8'h88;
        rv8 = 1'b1;
        tick();
        rv8 = 1'b0;
        chk("t6_sync_data", {24'h0, txd8}, 32'hA5);
        start = fd8_cnt;
        repeat (6) tick();
        chk("t6_queue_empty", q8.size(), 0);
        chk("t6_frame_done", {31'h0, fd8}, 32'h1);
        tick();
        chk("t6_frame_done_count", fd8_cnt - start, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
